// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with a windowed 8-bit register file, wait states and write counter
module apb_slave_regfile #(
    parameter logic [7:0] BASE_ADDR   = 8'hA8,
    parameter int         DEPTH       = 8,
    parameter int         WAIT_CYCLES = 0,
    parameter logic [7:0] RESET_VAL   = 8'h00
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel_i,
    input  logic       penable_i,
    input  logic [7:0] paddr_i,
    input  logic       pwrite_i,
    input  logic [7:0] pwdata_i,
    output logic [7:0] prdata_o,
    output logic       pready_o,
    output logic       pslverr_o,
    output logic [7:0] wr_count_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [7:0]       addr_q;
    logic             pwrite_q;
    logic [3:0]       cnt_q;
    logic [7:0]       wr_count_q;
    logic [7:0]       regs [DEPTH];

    logic [7:0]       offset;
    logic             hit;
    logic [IDX_W-1:0] idx;
    logic             setup;
    logic             complete;

    // Decode the SETUP-captured address against the register window
    always_comb begin
        offset = addr_q - BASE_ADDR;
        hit    = (addr_q >= BASE_ADDR) && (offset < 8'(DEPTH));
        idx    = offset[IDX_W-1:0];
    end

    // Handshake terms and response outputs; all quiet outside ACCESS
    always_comb begin
        setup     = (state_q == S_IDLE) && psel_i && !penable_i;
        pready_o  = (state_q == S_ACCESS) && (cnt_q == 4'd0);
        complete  = pready_o && psel_i && penable_i;
        pslverr_o = pready_o && !hit;
        prdata_o  = (pready_o && !pwrite_q && hit) ? regs[idx] : 8'h00;
    end

    // Next-state logic: SETUP enters ACCESS, completion or deselect returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!psel_i || complete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register, captured address/direction and wait-state counter
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q  <= S_IDLE;
            addr_q   <= 8'h00;
            pwrite_q <= 1'b0;
            cnt_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            if (setup) begin
                addr_q   <= paddr_i;
                pwrite_q <= pwrite_i;
                cnt_q    <= 4'(WAIT_CYCLES);
            end else if ((state_q == S_ACCESS) && psel_i && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Register file and saturating write counter, updated only on an in-window write completion
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
            wr_count_q <= 8'h00;
        end else if (complete && pwrite_q && hit) begin
            regs[idx] <= pwdata_i;
            if (wr_count_q != 8'hFF) begin
                wr_count_q <= wr_count_q + 8'd1;
            end
        end
    end

    assign wr_count_o = wr_count_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard bench for apb_slave_regfile at 0, 2 and 3 wait states
module tb_apb_slave_regfile;

    logic       pclk = 1'b0;
    logic       preset;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;

    // unit 0: WAIT_CYCLES=0, unit 1: WAIT_CYCLES=2, unit 2: WAIT_CYCLES=3
    logic       psel_a    [3];
    logic [7:0] prdata_a  [3];
    logic       pready_a  [3];
    logic       pslverr_a [3];
    logic [7:0] wrc_a     [3];

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       is_read;
        int         waits;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] model  [3][8];
    int         wr_exp [3];
    int         waits_of [3] = '{0, 2, 3};
    int         checks = 0;
    int         errors = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.WAIT_CYCLES(0)) dut_w0 (
        .pclk(pclk), .preset(preset), .psel_i(psel_a[0]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .prdata_o(prdata_a[0]), .pready_o(pready_a[0]), .pslverr_o(pslverr_a[0]),
        .wr_count_o(wrc_a[0])
    );

    apb_slave_regfile #(.WAIT_CYCLES(2)) dut_w2 (
        .pclk(pclk), .preset(preset), .psel_i(psel_a[1]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .prdata_o(prdata_a[1]), .pready_o(pready_a[1]), .pslverr_o(pslverr_a[1]),
        .wr_count_o(wrc_a[1])
    );

    apb_slave_regfile #(.WAIT_CYCLES(3)) dut_w3 (
        .pclk(pclk), .preset(preset), .psel_i(psel_a[2]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .prdata_o(prdata_a[2]), .pready_o(pready_a[2]), .pslverr_o(pslverr_a[2]),
        .wr_count_o(wrc_a[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_models();
        for (int u = 0; u < 3; u++) begin
            wr_exp[u] = 0;
            for (int r = 0; r < 8; r++) model[u][r] = 8'h00;
        end
    endtask

    // One full APB transfer; paddr/pwrite are scrambled during ACCESS to prove they are ignored
    task automatic xfer(input int u, input logic [7:0] addr, input logic wr, input logic [7:0] data);
        exp_t e;
        int   waits;
        bit   done;
        logic hit;
        hit       = (addr >= 8'hA8) && (addr <= 8'hAF);
        e.err     = !hit;
        e.is_read = !wr;
        e.rdata   = (!wr && hit) ? model[u][addr[2:0]] : 8'h00;
        e.waits   = waits_of[u];
        exp_q.push_back(e);
        @(posedge pclk); #1;
        psel_a[u] = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = ~addr; pwrite = ~wr;
        waits = 0;
        done  = 0;
        while (!done) begin
            @(negedge pclk);
            if (pready_a[u]) begin
                e = exp_q.pop_front();
                check("wait_states", waits, e.waits);
                check("pslverr", {31'd0, pslverr_a[u]}, {31'd0, e.err});
                if (e.is_read) check("prdata", {24'd0, prdata_a[u]}, {24'd0, e.rdata});
                done = 1;
            end else begin
                check("pslverr_waiting", {31'd0, pslverr_a[u]}, 32'd0);
                waits++;
                if (waits > 40) begin
                    checks++;
                    errors++;
                    $error("FAIL pready_timeout observed=0 expected=1");
                    void'(exp_q.pop_front());
                    done = 1;
                end
            end
            @(posedge pclk); #1;
        end
        psel_a[u] = 1'b0; penable = 1'b0;
        if (wr && hit) begin
            model[u][addr[2:0]] = data;
            if (wr_exp[u] < 255) wr_exp[u]++;
        end
        @(negedge pclk);
        check("wr_count", {24'd0, wrc_a[u]}, wr_exp[u]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        preset = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        for (int u = 0; u < 3; u++) psel_a[u] = 1'b0;
        reset_models();
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_pready", {31'd0, pready_a[0]}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr_a[0]}, 32'd0);
        check("rst_prdata", {24'd0, prdata_a[0]}, 32'd0);
        check("rst_wr_count", {24'd0, wrc_a[0]}, 32'd0);
        #1 preset = 1'b0;

        // reset value, write/read at zero wait states
        xfer(0, 8'hAB, 1'b0, 8'h00);
        xfer(0, 8'hAB, 1'b1, 8'h5A);
        xfer(0, 8'hAB, 1'b0, 8'h00);

        // three wait states
        xfer(2, 8'hA8, 1'b0, 8'h00);
        xfer(2, 8'hAE, 1'b1, 8'hE1);
        xfer(2, 8'hAE, 1'b0, 8'h00);

        // out-of-window accesses and window edges
        xfer(0, 8'h10, 1'b1, 8'h77);
        xfer(0, 8'h10, 1'b0, 8'h00);
        xfer(0, 8'hA7, 1'b1, 8'h11);
        xfer(0, 8'hB0, 1'b1, 8'h22);
        xfer(0, 8'hAF, 1'b1, 8'h33);
        for (int r = 0; r < 8; r++) xfer(0, 8'hA8 + 8'(r), 1'b0, 8'h00);

        // abort after one ACCESS cycle at two wait states
        @(posedge pclk); #1;
        psel_a[1] = 1'b1; penable = 1'b0; paddr = 8'hAC; pwrite = 1'b1; pwdata = 8'hC3;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("abort_pready", {31'd0, pready_a[1]}, 32'd0);
        @(posedge pclk); #1;
        psel_a[1] = 1'b0; penable = 1'b0;
        repeat (3) begin
            @(negedge pclk);
            check("abort_idle_pready", {31'd0, pready_a[1]}, 32'd0);
        end
        xfer(1, 8'hAC, 1'b0, 8'h00);
        xfer(1, 8'hA9, 1'b1, 8'h3C);
        xfer(1, 8'hA9, 1'b0, 8'h00);

        // saturating write counter
        for (int i = 0; i < 260; i++) xfer(0, 8'hA8 + 8'(i % 8), 1'b1, 8'($urandom));
        check("wr_count_sat", {24'd0, wrc_a[0]}, 32'hFF);
        for (int r = 0; r < 8; r++) xfer(0, 8'hA8 + 8'(r), 1'b0, 8'h00);

        // reset asserted mid-ACCESS on a write
        @(posedge pclk); #1;
        psel_a[2] = 1'b1; penable = 1'b0; paddr = 8'hA9; pwrite = 1'b1; pwdata = 8'h99;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        #1;
        check("midrst_pready", {31'd0, pready_a[2]}, 32'd0);
        check("midrst_wr_count_w3", {24'd0, wrc_a[2]}, 32'd0);
        check("midrst_wr_count_w0", {24'd0, wrc_a[0]}, 32'd0);
        check("midrst_prdata", {24'd0, prdata_a[2]}, 32'd0);
        psel_a[2] = 1'b0; penable = 1'b0;
        reset_models();
        @(posedge pclk); #1;
        preset = 1'b0;
        xfer(2, 8'hA9, 1'b0, 8'h00);
        xfer(2, 8'hAE, 1'b0, 8'h00);
        xfer(0, 8'hAB, 1'b0, 8'h00);
        xfer(0, 8'hAD, 1'b1, 8'h6B);
        xfer(0, 8'hAD, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
